ofmap_writeback: RTL and testbench

Downstream stage of the convolution engine. It consumes the 16-bit convolution result stream and packs it into 4-lane groups. Each group is run through the batch-norm unit under a start/fixed-latency protocol, and the normalised lanes are written back to the output SRAM as two 32-bit words per group. It replaces the ad-hoc BN sequencing in the accelerator top level and adds address generation, group buffering, end-of-frame flush and completion signalling.

---
 rtl/wb_pkg.sv | 20 ++
 rtl/ofmap_writeback_if.sv | 27 ++
 rtl/wb_group_fifo.sv | 56 +++++
 rtl/ofmap_writeback.sv | 195 +++++++++++++++++++
 tb/tb_ofmap_writeback.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared types for the ofmap writeback path: lane/group containers and the
// sequencer state encoding.
package wb_pkg;

  localparam int DW     = 16;
  localparam int LANES  = 4;
  localparam int ADDR_W = 13;

  typedef logic signed [DW-1:0] lane_t;
  typedef lane_t [LANES-1:0] group_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    WR0,
    WR1
  } wb_state_e;

endpackage

// File: rtl/ofmap_writeback_if.sv
// Conv-result input, batch-norm start/result and output-SRAM write bundle
// of the ofmap writeback stage.
interface ofmap_writeback_if #(
  parameter int ADDR_W = 13
);

  logic              din_valid;
  logic [31:0]       din;
  logic              conv_done;
  logic              bn_start;
  logic [63:0]       bn_input;
  logic [63:0]       bn_output;
  logic              sram_wr_en;
  logic [ADDR_W-1:0] sram_wr_addr;
  logic [31:0]       sram_wr_data;

  modport slave (
    input  din_valid, din, conv_done, bn_output,
    output bn_start, bn_input, sram_wr_en, sram_wr_addr, sram_wr_data
  );

  modport master (
    output din_valid, din, conv_done, bn_output,
    input  bn_start, bn_input, sram_wr_en, sram_wr_addr, sram_wr_data
  );

endinterface

// File: rtl/wb_group_fifo.sv
// Two-entry FIFO of packed lane groups; a push against a full FIFO is
// accepted when a pop happens in the same cycle, otherwise it is dropped.
module wb_group_fifo
  import wb_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   clear,
  input  logic   push,
  input  group_t push_data,
  input  logic   pop,
  output group_t head,
  output logic   full,
  output logic   empty,
  output logic   drop
);

  group_t     mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       wr;
  logic       rd;

  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);
  assign rd    = pop & ~empty;
  assign wr    = push & (~full | rd);
  assign drop  = push & full & ~rd;
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (clear) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (wr) wr_ptr <= ~wr_ptr;
      if (rd) rd_ptr <= ~rd_ptr;
      case ({wr, rd})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ofmap_writeback.sv
// Packs the conv result stream into 4-lane groups, sequences them through BN
// and writes two 32-bit words per group. Optional ReLU: define WB_RELU_EN.
module ofmap_writeback #(
  parameter int                DW         = 16,
  parameter int                BN_LAT     = 13,
  parameter int                ADDR_W     = 13,
  parameter logic [ADDR_W-1:0] OFMAP_BASE = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  ofmap_writeback_if.slave    bus,
  output logic                busy,
  output logic                wb_done,
  output logic                overflow
);
  import wb_pkg::*;

  localparam int CW = $clog2(BN_LAT + 1);

  wb_state_e         state;
  wb_state_e         state_n;
  logic [1:0]        lane_cnt;
  logic [1:0]        cnt_n;
  logic [4*DW-1:0]   pack;
  logic [4*DW-1:0]   pack_n;
  logic              push;
  logic [4*DW-1:0]   push_grp;
  logic              pop;
  group_t            head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_drop;
  logic [CW-1:0]     wait_cnt;
  logic              wait_last;
  group_t            res_p0;
  logic [ADDR_W-1:0] addr;
  logic              done_seen;
  logic              done_cond;
  logic              bn_start;
  logic [63:0]       bn_input;
  logic              wr_en;
  logic [31:0]       wr_data;
  logic              unused_din;

  assign unused_din = ^bus.din[31:DW];

  // Right-aligns a partial group so the first sample lands in lane0.
  function automatic logic [4*DW-1:0] zero_fill(input logic [4*DW-1:0] p,
                                                input logic [1:0] k);
    case (k)
      2'd1:    zero_fill = {{(3*DW){1'b0}}, p[4*DW-1:3*DW]};
      2'd2:    zero_fill = {{(2*DW){1'b0}}, p[4*DW-1:2*DW]};
      2'd3:    zero_fill = {{DW{1'b0}}, p[4*DW-1:DW]};
      default: zero_fill = p;
    endcase
  endfunction

  function automatic group_t relu_grp(input group_t g);
    group_t r;
    r = g;
`ifdef WB_RELU_EN
    for (int i = 0; i < LANES; i++) begin
      if (g[i][DW-1]) r[i] = '0;
    end
`endif
    return r;
  endfunction

  always_comb begin
    pack_n   = pack;
    cnt_n    = lane_cnt;
    push     = 1'b0;
    push_grp = pack;
    if (bus.din_valid) begin
      pack_n = {bus.din[DW-1:0], pack[4*DW-1:DW]};
      cnt_n  = lane_cnt + 2'd1;
      if (lane_cnt == 2'd3) begin
        push     = 1'b1;
        push_grp = pack_n;
      end
    end
    // The sample of this cycle is already counted when a flush is decided.
    if (bus.conv_done && cnt_n != 2'd0) begin
      push     = 1'b1;
      push_grp = zero_fill(pack_n, cnt_n);
      cnt_n    = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    pack <= pack_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     lane_cnt <= 2'd0;
    else if (clear) lane_cnt <= 2'd0;
    else            lane_cnt <= cnt_n;
  end

  wb_group_fifo u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .push      (push),
    .push_data (group_t'(push_grp)),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .drop      (fifo_drop)
  );

  // p0: BN result captured on the last wait cycle
  assign wait_last = (state == WAIT) && (wait_cnt == CW'(BN_LAT - 1));

  always_ff @(posedge clk) begin
    if (wait_last) res_p0 <= relu_grp(group_t'(bus.bn_output));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     state <= IDLE;
    else if (clear) state <= IDLE;
    else            state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (!fifo_empty) state_n = START;
      START:   state_n = WAIT;
      WAIT:    if (wait_last) state_n = WR0;
      WR0:     state_n = WR1;
      WR1:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    bn_start = 1'b0;
    bn_input = '0;
    pop      = 1'b0;
    wr_en    = 1'b0;
    wr_data  = '0;
    case (state)
      START: begin
        bn_start = 1'b1;
        bn_input = head;
        pop      = 1'b1;
      end
      WR0: begin
        wr_en   = 1'b1;
        wr_data = {res_p0[1], res_p0[0]};
      end
      WR1: begin
        wr_en   = 1'b1;
        wr_data = {res_p0[3], res_p0[2]};
      end
      default: ;
    endcase
  end

  assign done_cond = done_seen && (lane_cnt == 2'd0) && fifo_empty &&
                     (state == IDLE) && !push;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt  <= '0;
      addr      <= OFMAP_BASE;
      done_seen <= 1'b0;
      wb_done   <= 1'b0;
      overflow  <= 1'b0;
    end else if (clear) begin
      wait_cnt  <= '0;
      addr      <= OFMAP_BASE;
      done_seen <= 1'b0;
      wb_done   <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      wait_cnt  <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
      if (wr_en) addr <= addr + 1'b1;
      done_seen <= (done_seen & ~done_cond) | bus.conv_done;
      wb_done   <= done_cond;
      if (fifo_drop) overflow <= 1'b1;
    end
  end

  assign busy             = (lane_cnt != 2'd0) | ~fifo_empty | (state != IDLE);
  assign bus.bn_start     = bn_start;
  assign bus.bn_input     = bn_input;
  assign bus.sram_wr_en   = wr_en;
  assign bus.sram_wr_addr = addr;
  assign bus.sram_wr_data = wr_data;

endmodule

// File: tb/tb_ofmap_writeback.sv
// Directed bench for ofmap_writeback with a fixed-latency BN stub (+1 per
// lane); a second instance with OFMAP_BASE=8190 mirrors the stimulus.
module tb_ofmap_writeback;

  localparam int BN_LAT = 13;
  localparam int ADDR_W = 13;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  logic busy, wb_done, overflow;
  logic busy_w, wb_done_w, overflow_w;

  always #5 clk = ~clk;

  ofmap_writeback_if #(.ADDR_W(ADDR_W)) ifm ();
  ofmap_writeback_if #(.ADDR_W(ADDR_W)) ifw ();

  ofmap_writeback #(.DW(16), .BN_LAT(BN_LAT), .ADDR_W(ADDR_W), .OFMAP_BASE(13'd0)) u_dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bus(ifm.slave),
    .busy(busy), .wb_done(wb_done), .overflow(overflow)
  );

  ofmap_writeback #(.DW(16), .BN_LAT(BN_LAT), .ADDR_W(ADDR_W), .OFMAP_BASE(13'd8190)) u_wrap (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bus(ifw.slave),
    .busy(busy_w), .wb_done(wb_done_w), .overflow(overflow_w)
  );

  assign ifw.din_valid = ifm.din_valid;
  assign ifw.din       = ifm.din;
  assign ifw.conv_done = ifm.conv_done;
  assign ifw.bn_output = '0;

  function automatic logic [63:0] lanes_plus1(input logic [63:0] v);
    logic [63:0] r;
    for (int i = 0; i < 4; i++) r[16*i +: 16] = v[16*i +: 16] + 16'd1;
    return r;
  endfunction

  logic [63:0]       bn_hold = '0;
  logic [BN_LAT-1:0] bn_sh = '0;
  always @(posedge clk) begin
    bn_sh <= {bn_sh[BN_LAT-2:0], ifm.bn_start};
    if (ifm.bn_start) bn_hold <= ifm.bn_input;
  end
  assign ifm.bn_output = bn_sh[BN_LAT-1] ? lanes_plus1(bn_hold) : 64'hDEAD_BEEF_DEAD_BEEF;

  int                cyc = 0;
  int                done_cnt = 0;
  logic [ADDR_W-1:0] wa_q[$];
  logic [31:0]       wd_q[$];
  int                wc_q[$];
  logic [63:0]       bi_q[$];
  int                bc_q[$];
  logic [ADDR_W-1:0] waw_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ifm.sram_wr_en) begin
      wa_q.push_back(ifm.sram_wr_addr);
      wd_q.push_back(ifm.sram_wr_data);
      wc_q.push_back(cyc);
    end
    if (ifm.bn_start) begin
      bi_q.push_back(ifm.bn_input);
      bc_q.push_back(cyc);
    end
    if (wb_done) done_cnt = done_cnt + 1;
    if (ifw.sram_wr_en) waw_q.push_back(ifw.sram_wr_addr);
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] v);
    ifm.din_valid = 1'b1;
    ifm.din       = {16'hA5A5, v};
    tick();
    ifm.din_valid = 1'b0;
  endtask

  task automatic pulse_done();
    ifm.conv_done = 1'b1;
    tick();
    ifm.conv_done = 1'b0;
  endtask

  task automatic clear_q();
    wa_q.delete(); wd_q.delete(); wc_q.delete();
    bi_q.delete(); bc_q.delete();
  endtask

  task automatic wait_wr(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && wa_q.size() < n; i++) tick();
    check_eq(tag, 64'(wa_q.size()), 64'(n));
    while (wa_q.size() < n) begin
      wa_q.push_back('1); wd_q.push_back('1); wc_q.push_back(-1);
    end
  endtask

  task automatic wait_start(input string tag, input int budget);
    for (int i = 0; i < budget && bi_q.size() == 0; i++) tick();
    check_eq(tag, 64'(bi_q.size()), 64'd1);
    if (bi_q.size() == 0) begin
      bi_q.push_back('1); bc_q.push_back(-1000);
    end
  endtask

  initial begin
    ifm.din_valid = 1'b0;
    ifm.din       = '0;
    ifm.conv_done = 1'b0;
    tick(3);
    check_eq("rst_bn_start", 64'(ifm.bn_start), 64'd0);
    check_eq("rst_bn_input", ifm.bn_input, 64'd0);
    check_eq("rst_wr_en", 64'(ifm.sram_wr_en), 64'd0);
    check_eq("rst_wr_addr", 64'(ifm.sram_wr_addr), 64'd0);
    check_eq("rst_wr_data", 64'(ifm.sram_wr_data), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_wb_done", 64'(wb_done), 64'd0);
    check_eq("rst_overflow", 64'(overflow), 64'd0);
    check_eq("rst_wrap_addr", 64'(ifw.sram_wr_addr), 64'd8190);
    rst_n = 1'b1;
    tick(2);

    clear_q();
    send(16'd1); send(16'd2); send(16'd3); send(16'd4);
    check_eq("basic_busy", 64'(busy), 64'd1);
    wait_wr("basic_nwr", 2, 60);
    check_eq("basic_bn_input", bi_q[0], 64'h0004_0003_0002_0001);
    check_eq("basic_lat0", 64'(wc_q[0] - bc_q[0]), 64'(BN_LAT + 1));
    check_eq("basic_lat1", 64'(wc_q[1] - bc_q[0]), 64'(BN_LAT + 2));
    check_eq("basic_addr0", 64'(wa_q[0]), 64'd0);
    check_eq("basic_data0", 64'(wd_q[0]), 64'h0003_0002);
    check_eq("basic_addr1", 64'(wa_q[1]), 64'd1);
    check_eq("basic_data1", 64'(wd_q[1]), 64'h0005_0004);
    tick(3);

    clear_q();
    done_cnt = 0;
    send(16'd5); send(16'd6);
    pulse_done();
    wait_wr("part_nwr", 2, 60);
    check_eq("part_bn_input", bi_q[0], 64'h0000_0000_0006_0005);
    check_eq("part_addr0", 64'(wa_q[0]), 64'd2);
    check_eq("part_data0", 64'(wd_q[0]), 64'h0007_0006);
    check_eq("part_data1", 64'(wd_q[1]), 64'h0001_0001);
    tick(6);
    check_eq("part_wb_done_cnt", 64'(done_cnt), 64'd1);
    check_eq("part_busy", 64'(busy), 64'd0);

    clear_q();
    send(16'hFFFC); send(16'h0006); send(16'hFFFE); send(16'hFFFF);
    wait_wr("relu_nwr", 2, 60);
    check_eq("relu_addr0", 64'(wa_q[0]), 64'd4);
`ifdef WB_RELU_EN
    check_eq("relu_data0", 64'(wd_q[0]), 64'h0007_0000);
    check_eq("relu_data1", 64'(wd_q[1]), 64'h0000_0000);
`else
    check_eq("relu_data0", 64'(wd_q[0]), 64'h0007_FFFD);
    check_eq("relu_data1", 64'(wd_q[1]), 64'h0000_FFFF);
`endif
    tick(3);

    clear_q();
    send(16'h20); send(16'h21); send(16'h22); send(16'h23);
    wait_start("burst_p_start", 20);
    for (int i = 0; i < 12; i++) send(16'(16'h10 + i));
    check_eq("burst_overflow", 64'(overflow), 64'd1);
    wait_wr("burst_nwr", 6, 120);
    tick(40);
    check_eq("burst_total_wr", 64'(wa_q.size()), 64'd6);
    check_eq("burst_g1_data0", 64'(wd_q[2]), 64'h0012_0011);
    check_eq("burst_g1_data1", 64'(wd_q[3]), 64'h0014_0013);
    check_eq("burst_g2_data0", 64'(wd_q[4]), 64'h0016_0015);
    check_eq("burst_g2_data1", 64'(wd_q[5]), 64'h0018_0017);
    check_eq("burst_last_addr", 64'(wa_q[5]), 64'd11);
    check_eq("burst_ovf_sticky", 64'(overflow), 64'd1);

    clear_q();
    send(16'h30); send(16'h31); send(16'h32); send(16'h33);
    wait_start("clr_start", 20);
    tick(5);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick(25);
    check_eq("clr_no_write", 64'(wa_q.size()), 64'd0);
    check_eq("clr_addr", 64'(ifm.sram_wr_addr), 64'd0);
    check_eq("clr_overflow", 64'(overflow), 64'd0);
    check_eq("clr_busy", 64'(busy), 64'd0);
    send(16'h41); send(16'h42); send(16'h43); send(16'h44);
    wait_wr("clr_next_nwr", 2, 60);
    check_eq("clr_next_addr0", 64'(wa_q[0]), 64'd0);
    check_eq("clr_next_data0", 64'(wd_q[0]), 64'h0043_0042);
    check_eq("clr_next_data1", 64'(wd_q[1]), 64'h0045_0044);

    while (waw_q.size() < 4) waw_q.push_back('1);
    check_eq("wrap_addr0", 64'(waw_q[0]), 64'd8190);
    check_eq("wrap_addr1", 64'(waw_q[1]), 64'd8191);
    check_eq("wrap_addr2", 64'(waw_q[2]), 64'd0);
    check_eq("wrap_addr3", 64'(waw_q[3]), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
